// File: rtl/vmult_lane_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vmult_lane_seq
//  Brief    : Lane sequencer around the combinational FP16 lane multiplier.
//             Optional macro VMULT_SAT_EN clamps overflowed lanes to max finite.
//  Revision : 1.0  initial release
// ============================================================================
module vmult_lane_seq #(
    parameter int LANES = 16,
    parameter int DW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LANES*DW-1:0]   vec_a,
    input  logic [LANES*DW-1:0]   vec_b,
    output logic [DW-1:0]         mult_a,
    output logic [DW-1:0]         mult_b,
    input  logic [DW-1:0]         mult_prod,
    input  logic                  mult_ovf,
    output logic                  busy,
    output logic                  done,
    output logic [LANES*DW-1:0]   result,
    output logic [LANES-1:0]      ovf_lane,
    output logic                  ovf_any
);

    localparam int              IW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0]   C_LAST = IW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [IW-1:0]          r_idx;
    logic [LANES*DW-1:0]    r_op_a;
    logic [LANES*DW-1:0]    r_op_b;
    logic [LANES*DW-1:0]    r_result;
    logic [LANES-1:0]       r_ovf;
    logic [DW-1:0]          w_lane_val;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_idx == C_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef VMULT_SAT_EN
    // Overflowed lanes become the signed largest finite value instead of infinity.
    assign w_lane_val = mult_ovf ? {mult_prod[DW-1], 15'h7BFF} : mult_prod;
`else
    assign w_lane_val = mult_prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_ovf    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a   <= vec_a;
                        r_op_b   <= vec_b;
                        r_result <= '0;
                        r_ovf    <= '0;
                        r_idx    <= '0;
                    end
                end
                S_RUN: begin
                    r_result[r_idx*DW +: DW] <= w_lane_val;
                    r_ovf[r_idx]             <= mult_ovf;
                    r_idx                    <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mult_a   = (r_state == S_RUN) ? r_op_a[r_idx*DW +: DW] : '0;
    assign mult_b   = (r_state == S_RUN) ? r_op_b[r_idx*DW +: DW] : '0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign ovf_lane = r_ovf;
    assign ovf_any  = |r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vmult_lane_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vmult_lane_seq
//  Brief    : Directed self-checking bench for vmult_lane_seq with a stub multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vmult_lane_seq;

    localparam int LANES = 16;
    localparam int DW    = 16;
    localparam int VW    = LANES * DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [VW-1:0]     vec_a;
    logic [VW-1:0]     vec_b;
    logic [DW-1:0]     mult_a;
    logic [DW-1:0]     mult_b;
    logic [DW-1:0]     mult_prod;
    logic              mult_ovf;
    logic              busy;
    logic              done;
    logic [VW-1:0]     result;
    logic [LANES-1:0]  ovf_lane;
    logic              ovf_any;

    int tests = 0;
    int fails = 0;

    vmult_lane_seq #(.LANES(LANES), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_prod (mult_prod),
        .mult_ovf  (mult_ovf),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf_lane  (ovf_lane),
        .ovf_any   (ovf_any)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact FP16 products for the directed pairs, a+b otherwise.
    always_comb begin
        mult_prod = mult_a + mult_b;
        mult_ovf  = 1'b0;
        case ({mult_a, mult_b})
            32'h4000_4200: mult_prod = 16'h4600;
            32'h7800_7800: begin mult_prod = 16'h7C00; mult_ovf = 1'b1; end
            32'h3C00_3C00: mult_prod = 16'h3C00;
            32'hC000_4000: mult_prod = 16'hC400;
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept one operation, scramble inputs, and return edges from accept to done.
    task automatic run_op(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          output int lat);
        vec_a = a;
        vec_b = b;
        start = 1'b1;
        step();
        start = 1'b0;
        vec_a = '1;
        vec_b = '1;
        check({tag, "_busy"}, VW'(busy), VW'(1));
        check({tag, "_clr"}, {result[VW-1:LANES], ovf_lane}, '0);
        check({tag, "_ma0"}, VW'(mult_a), VW'(a[DW-1:0]));
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
        check_int({tag, "_lat"}, lat, LANES);
    endtask

    logic [VW-1:0] a_v, b_v, exp_v;
    int lat;
    int ndone, nacc, last_acc;
    logic prev_busy, prev_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        vec_a = '0;
        vec_b = '0;
        #1;
        check("rst_result", result, '0);
        check("rst_ovf", VW'(ovf_lane), '0);
        check("rst_flags", VW'({busy, done, ovf_any}), '0);
        check("rst_mult", VW'({mult_a, mult_b}), '0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // All lanes 2.0 x 3.0
        for (int i = 0; i < LANES; i++) begin
            a_v[i*DW +: DW] = 16'h4000;
            b_v[i*DW +: DW] = 16'h4200;
            exp_v[i*DW +: DW] = 16'h4600;
        end
        run_op("mul23", a_v, b_v, lat);
        check("mul23_res", result, exp_v);
        check("mul23_ovf", VW'({ovf_any, ovf_lane}), '0);
        step();
        check("mul23_idle", VW'({busy, done}), '0);

        // Lane 3 overflows
        for (int i = 0; i < LANES; i++) begin
            a_v[i*DW +: DW] = (i == 3) ? 16'h7800 : 16'h3C00;
            b_v[i*DW +: DW] = (i == 3) ? 16'h7800 : 16'h3C00;
            exp_v[i*DW +: DW] = 16'h3C00;
        end
`ifdef VMULT_SAT_EN
        exp_v[3*DW +: DW] = 16'h7BFF;
`else
        exp_v[3*DW +: DW] = 16'h7C00;
`endif
        run_op("ovf3", a_v, b_v, lat);
        check("ovf3_res", result, exp_v);
        check("ovf3_lane", VW'(ovf_lane), VW'(16'h0008));
        check("ovf3_any", VW'(ovf_any), VW'(1));
        step();

        // Negative lane 0, distinct pass-through values on the other lanes
        for (int i = 0; i < LANES; i++) begin
            a_v[i*DW +: DW] = (i == 0) ? 16'hC000 : DW'(i * 16'h0111);
            b_v[i*DW +: DW] = (i == 0) ? 16'h4000 : DW'(i + 1);
            exp_v[i*DW +: DW] = (i == 0) ? 16'hC400 : DW'(i * 16'h0111 + i + 1);
        end
        run_op("neg", a_v, b_v, lat);
        check("neg_res", result, exp_v);
        check("neg_ovf", VW'(ovf_any), '0);
        step();

        // Reset while lane 5 is in flight
        vec_a = a_v;
        vec_b = b_v;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("mid_ma5", VW'(mult_a), VW'(a_v[5*DW +: DW]));
        #2 rst_n = 1'b0;
        #1;
        check("mid_result", result, '0);
        check("mid_flags", VW'({busy, done, ovf_lane}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 25; n++) begin
            step();
            if (done) ndone++;
        end
        check_int("mid_nodone", ndone, 0);
        check("mid_hold", result, '0);

        // start held high: acceptances every LANES+2 cycles
        for (int i = 0; i < LANES; i++) begin
            a_v[i*DW +: DW] = 16'h4000;
            b_v[i*DW +: DW] = 16'h4200;
            exp_v[i*DW +: DW] = 16'h4600;
        end
        vec_a = a_v;
        vec_b = b_v;
        start = 1'b1;
        prev_busy = busy;
        prev_done = 1'b0;
        ndone = 0;
        nacc = 0;
        last_acc = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (busy && !prev_busy) begin
                if (nacc > 0) check_int("held_gap", n - last_acc, LANES + 2);
                nacc++;
                last_acc = n;
            end
            if (prev_done) check("held_no_dacc", VW'(busy), '0);
            if (done) begin
                ndone++;
                check("held_res", result, exp_v);
            end
            prev_busy = busy;
            prev_done = done;
        end
        start = 1'b0;
        check_int("held_acc", nacc, 4);
        check_int("held_done", ndone, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
